// File: rtl/boot_loader.sv
// Byte-stream program loader: assembles LE words into imem, then releases the core.
// Ports: clk, rst(async low), rx_*(valid/ready), imem_*(write), core_rst, done, error. Option: LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int unsigned IW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          buf_q, buf_d;
  logic [IW-1:0]        widx_q, widx_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 rdy_q, rdy_d;
  logic                 crst_q, crst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 fire;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
  logic [7:0]           ck;
`endif

  assign fire = rx_valid & rdy_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    widx_d     = widx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    ck         = sum_q + rx_byte;
    if (fire && (state_q inside {LEN_LO, LEN_HI, DATA}))
      sum_d = ck;
`endif
    case (state_q)
      LEN_LO: begin
        if (fire) begin
          len_d   = LEN_WIDTH'(rx_byte);
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (fire) begin
          len_d = LEN_WIDTH'({rx_byte, len_q[7:0]});
          if (len_d == '0)
            state_d = CHECK;
          else if (32'(len_d) > DEPTH)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word complete: write lands next cycle, stream keeps flowing.
            we_d    = 1'b1;
            wdata_d = {rx_byte, buf_q};
            addr_d  = BASE_ADDR + (32'(widx_q) << 2);
            widx_d  = widx_q + IW'(1);
            if (32'(widx_q) + 32'd1 == 32'(len_q))
              state_d = CHECK;
          end else begin
            buf_d = {rx_byte, buf_q[23:8]};
          end
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (fire)
          state_d = (ck == 8'h00) ? RUN : ERROR;
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    // Status outputs are registered images of the next state.
`ifdef LOADER_CHECKSUM_EN
    rdy_d  = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
`else
    rdy_d  = state_d inside {LEN_LO, LEN_HI, DATA};
`endif
    crst_d = (state_d == RUN);
    done_d = (state_d == RUN);
    err_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN_LO;
      len_q      <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      widx_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      rdy_q      <= 1'b0;
      crst_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      widx_q     <= widx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      crst_q     <= crst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end
`endif

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = crst_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader against a byte-image reference model.
// Checks write stream, terminal status, handshake and reset behaviour.
module tb_boot_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  boot_loader #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_we_cyc = 0;
  int         n_we_load = 0;
  logic       cr_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every pulse must match the model's next write.
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (rst && imem_we) begin
      n_we_load++;
      last_we_cyc = cyc;
      check("we_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("imem_addr", imem_addr, w.a);
        check("imem_wdata", imem_wdata, w.d);
      end
    end
`ifndef LOADER_CHECKSUM_EN
    if (rst && core_rst && !cr_prev && n_we_load > 0)
      check("core_rst_latency", cyc, last_we_cyc + 1);
`endif
    cr_prev = core_rst;
  end

  task automatic check_reset_outs();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, BASE);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_reset_outs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", rx_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_byte = b;
    while (!ok && n < 50) begin
      if (rx_ready) ok = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    rx_valid = 1'b0;
    rx_byte = 8'($urandom);
  endtask

  task automatic add_trailer(input bit good);
`ifdef LOADER_CHECKSUM_EN
    int s = 0;
    int t;
    foreach (img[k]) s += img[k];
    t = (256 - (s % 256)) % 256;
    if (!good) t = (t + 1 + $urandom_range(0, 254)) % 256;
    img.push_back(8'(t));
`else
    if (good) return;
`endif
  endtask

  task automatic build_image(input int len, input bit good);
    img.delete();
    img.push_back(8'(len));
    img.push_back(8'(len >> 8));
    if (len <= DEPTH) begin
      for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
      add_trailer(good);
    end
  endtask

  // Reference model: derive expected writes and outcome from img, then stream it.
  task automatic run_load(input int smin, input int smax);
    int  len, nsend, nacc, nw, w;
    bit  exp_ok, ok;
    len = {img[1], img[0]};
    exp_ok = (len <= DEPTH);
    nw = 0;
    if (exp_ok) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back('{BASE + 32'(4 * i),
          {img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]}});
      nw = len;
`ifdef LOADER_CHECKSUM_EN
      begin
        int s = 0;
        for (int k = 0; k < 2 + 4 * len; k++) s += img[k];
        exp_ok = ((s + img[2 + 4 * len]) % 256) == 0;
      end
`endif
    end
    nsend = (len > DEPTH) ? 2 : img.size();
    n_we_load = 0;
    nacc = 0;
    for (int k = 0; k < nsend; k++) begin
      send_byte(img[k], ok);
      if (ok) nacc++;
      repeat ($urandom_range(smin, smax)) @(negedge clk);
    end
    check("bytes_accepted", nacc, nsend);
    w = 0;
    while (!(done || error) && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (smax == 0) check("status_latency", 32'(w <= 1), 1);
    @(negedge clk);
    #1;
    check("done", done, 32'(exp_ok));
    check("error", error, 32'(!exp_ok));
    check("core_rst", core_rst, 32'(exp_ok));
    check("rx_ready_end", rx_ready, 0);
    check("writes_left", exp_q.size(), 0);
    check("write_count", n_we_load, nw);
    rx_valid = 1'b1;
    rx_byte = 8'($urandom);
    repeat (4) begin
      @(negedge clk);
      check("rx_ready_idle", rx_ready, 0);
    end
    rx_valid = 1'b0;
    check("done_sticky", done, 32'(exp_ok));
    check("error_sticky", error, 32'(!exp_ok));
  endtask

  task automatic basic_image();
    img.delete();
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
            8'h93, 8'h05, 8'h20, 8'h00};
    add_trailer(1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    #1;
    check_reset_outs();
    do_reset();

    basic_image();
    run_load(0, 0);

    do_reset();
    basic_image();
    run_load(3, 3);

    do_reset();
    img = '{8'h00, 8'h00};
    add_trailer(1'b1);
    run_load(0, 0);

    do_reset();
    img = '{8'h01, 8'h01};
    run_load(0, 0);

    do_reset();
    basic_image();
    for (int k = 0; k < 5; k++) send_byte(img[k], ok);
    rst = 1'b0;
    #1;
    check_reset_outs();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", rx_ready, 1);
    run_load(0, 1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    run_load(0, 0);
    do_reset();
    img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    run_load(0, 0);
`endif

    do_reset();
    build_image(DEPTH, 1'b1);
    run_load(0, 0);

    do_reset();
    build_image(DEPTH + 1 + $urandom_range(0, 65000), 1'b1);
    run_load(0, 2);

    for (int it = 0; it < 8; it++) begin
      do_reset();
      build_image($urandom_range(0, 6), $urandom_range(0, 3) != 0);
      run_load(0, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
